exec_stage: RTL and testbench
=============================

# exec_stage

Execute stage that sits directly downstream of the instruction decoder. It accepts a decoded operation (4-bit ALU code, register-write flag, destination register, two operands) over a valid/ready handshake, computes the result, and presents a registered one-cycle writeback beat to the register file. Single-cycle ops complete in one clock; MUL runs as a fixed-latency iterative shift-add, and the stage backpressures the decoder while it runs. A halt request drains in-flight work and parks the stage.

## Interface
- XLEN, 32, operand/result width; MUL iteration count equals XLEN
- clk  in  1  clock; all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- in_valid  in  1  decoded op present
- in_ready  out  1  stage can accept; transfer when in_valid && in_ready at an edge
- alu_control  in  4  0000 AND, 0001 OR, 0010 ADD, 0011 SLL, 0100 SUB, 0101 SRL, 0110 MUL, 0111 XOR; 1xxx illegal
- regwrite_in  in  1  decoder register-write request
- rd_in  in  5  destination register
- op_a, op_b  in  XLEN  operands
- wb_valid  out  1  one-cycle writeback beat
- wb_regwrite  out  1  write enable for the beat
- wb_rd  out  5  destination of the beat
- wb_data  out  XLEN  result
- illegal_op  out  1  one-cycle pulse, coincident with wb_valid, for an illegal code
- halt_req  in  1  level; request to stop accepting work
- halted  out  1  sticky until rst

## Operation
- States: IDLE, MUL, HALTED.
- IDLE: in_ready = !halt_req. On accept of a non-MUL op, compute combinationally and register the beat. On accept of MUL, latch operands, rd, and regwrite, clear counter, go to MUL.
- IDLE with halt_req high and no accept: go to HALTED.
- MUL: one shift-add iteration per edge. Counter runs 0..XLEN-1. The edge at count XLEN-1 registers the beat and returns to IDLE. in_ready = 0 throughout.
- HALTED: in_ready = 0; halted = 1. Leaves only via rst.
- Arithmetic:
  - ADD/SUB wrap modulo 2^XLEN.
  - SLL/SRL (logical) use op_b[4:0] as the shift amount.
  - MUL returns the low XLEN bits of the unsigned product, equal to the low bits of the signed product.
- Illegal code (1xxx): wb_data = 0, wb_regwrite = 0, illegal_op = 1, single-cycle.
- wb_regwrite = regwrite_in for legal ops. wb_rd is passed through unchanged, including rd 0; the register file ignores x0.
- halt_req during MUL: the multiply completes and writes back; HALTED is entered on the following edge.

## Timing
- Reset values:
  - Outputs: wb_valid, wb_regwrite, wb_rd, wb_data, illegal_op, and halted are all 0.
  - State: IDLE, counter 0.
  - in_ready is 0 while rst is high.
- Single-cycle op accepted at edge E: beat visible after E+1 for exactly one cycle. Back-to-back accepts every cycle give one beat per cycle.
- MUL accepted at edge E: beat visible after E+XLEN (32 for default). in_ready returns high in that same cycle, so the next accept can occur at E+XLEN+1.
- wb_valid is deasserted on every edge that does not produce a beat; there is no output backpressure.
- rst during MUL aborts the multiply with no beat; the stage is in IDLE on the next cycle.
- Inputs are sampled only at the accept edge; operand changes during MUL have no effect.

## Configuration
- EXEC_MUL_EN defined: MUL implemented as above.
- EXEC_MUL_EN undefined: code 0110 is treated as illegal (single-cycle, wb_data 0, wb_regwrite 0, illegal_op 1). No MUL state or multiplier hardware is built.

## Structure
- Package exec_pkg:
  - alu_op_e enum carrying the 4-bit codes listed above.
  - exec_state_e enum (IDLE, MUL, HALTED).
  - Default XLEN constant.
- Sub-module mul_iter: start/done, with an XLEN-cycle radix-2 shift-add datapath and counter. Instantiated only under EXEC_MUL_EN.

## Test plan
- ADD 0x7FFFFFFF + 1, rd=5, regwrite=1 -> next cycle wb_data=0x80000000, wb_rd=5, wb_regwrite=1, wb_valid for one cycle.
- SUB 0 - 1, then SLL 1 << 31, back-to-back -> beats 0xFFFFFFFF and 0x80000000 on consecutive cycles, in_ready held high.
- MUL 0xFFFFFFFF * 3 -> in_ready low for 32 cycles; beat 0xFFFFFFFD 32 cycles after accept. Without EXEC_MUL_EN: illegal_op pulse, wb_data=0 the next cycle.
- alu_control=1010 with regwrite=1 -> wb_valid=1, illegal_op=1, wb_regwrite=0, wb_data=0.
- halt_req raised 10 cycles into a MUL -> MUL beat still issues; halted=1 on the next cycle; in_ready stays 0 with in_valid held high.
- rst asserted at iteration 15 of a MUL -> no beat; all outputs 0; in_ready=1 in the first cycle after rst deasserts.

Source files
------------

// File: rtl/exec_pkg.sv
// Shared types for the execute stage: ALU op codes, FSM states, default width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package exec_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RD_W     = 5;

  // Decoder ALU codes; any code with bit 3 set is illegal.
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SLL = 4'b0011,
    ALU_SUB = 4'b0100,
    ALU_SRL = 4'b0101,
    ALU_MUL = 4'b0110,
    ALU_XOR = 4'b0111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    MUL    = 2'd1,
    HALTED = 2'd2
  } exec_state_e;

endpackage

// File: rtl/exec_if.sv
// Decoder-to-execute handshake plus the writeback beat and halt control.
// Latency: n/a (wires only).
// Backpressure: in_ready from the stage; the writeback side has none.
interface exec_if import exec_pkg::*; #(parameter int XLEN = XLEN_DEF);

  logic              in_valid;
  logic              in_ready;
  logic [3:0]        alu_control;
  logic              regwrite_in;
  logic [RD_W-1:0]   rd_in;
  logic [XLEN-1:0]   op_a;
  logic [XLEN-1:0]   op_b;
  logic              wb_valid;
  logic              wb_regwrite;
  logic [RD_W-1:0]   wb_rd;
  logic [XLEN-1:0]   wb_data;
  logic              illegal_op;
  logic              halt_req;
  logic              halted;

  // Decoder / register-file side.
  modport master (
    output in_valid, alu_control, regwrite_in, rd_in, op_a, op_b, halt_req,
    input  in_ready, wb_valid, wb_regwrite, wb_rd, wb_data, illegal_op, halted
  );

  // Execute stage side.
  modport slave (
    input  in_valid, alu_control, regwrite_in, rd_in, op_a, op_b, halt_req,
    output in_ready, wb_valid, wb_regwrite, wb_rd, wb_data, illegal_op, halted
  );

endinterface

// File: rtl/mul_iter.sv
// Radix-2 shift-add multiplier returning the low XLEN bits of the product.
// Latency: start at edge E, done asserted in the cycle before edge E+XLEN.
// Backpressure: none; the caller must not pulse start while busy.
module mul_iter import exec_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] product
);

  localparam int CW = $clog2(XLEN);

  logic            busy;
  logic [CW-1:0]   cnt;
  logic [XLEN-1:0] mcand;
  logic [XLEN-1:0] mplier;
  logic [XLEN-1:0] acc;

  // The final iteration's add is folded in combinationally so the caller
  // can register the finished product on the same edge as the last step.
  assign product = acc + (mplier[0] ? mcand : '0);
  assign done    = busy && (cnt == CW'(XLEN - 1));

  // One shift-add step per edge while busy; start reloads the operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      cnt    <= '0;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
    end else if (start) begin
      busy   <= 1'b1;
      cnt    <= '0;
      mcand  <= a;
      mplier <= b;
      acc    <= '0;
    end else if (busy) begin
      acc    <= product;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (done) begin
        busy <= 1'b0;
        cnt  <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/exec_stage.sv
// Execute stage: ALU ops to a registered writeback beat; MUL iterative when EXEC_MUL_EN is defined.
// Latency: single-cycle ops 1 clock; MUL XLEN clocks from accept to visible beat.
// Backpressure: in_ready low during MUL, while halt_req is high, once halted, and in reset.
module exec_stage import exec_pkg::*; #(
  parameter int XLEN = XLEN_DEF
) (
  input  logic   clk,
  input  logic   rst,
  exec_if.slave  bus
);

  exec_state_e     state, state_next;
  logic            accept;
  logic            is_mul;
  logic            legal;
  logic [XLEN-1:0] alu_res;

  logic            mul_done;
  logic [XLEN-1:0] mul_product;
  logic            mul_rw;
  logic [RD_W-1:0] mul_rd;

  logic            nx_vld;
  logic            nx_rw;
  logic            nx_ill;
  logic [RD_W-1:0] nx_rd;
  logic [XLEN-1:0] nx_data;

  assign bus.in_ready = !rst && (state == IDLE) && !bus.halt_req;
  assign bus.halted   = (state == HALTED);
  assign accept       = bus.in_valid && bus.in_ready;
  // MUL never reaches this check when the multiplier is built, so treating
  // its code as illegal here only matters in the build without it.
  assign legal        = !bus.alu_control[3] && (bus.alu_control != ALU_MUL);

`ifdef EXEC_MUL_EN
  logic mul_start;

  assign is_mul    = (bus.alu_control == ALU_MUL);
  assign mul_start = accept && is_mul;

  mul_iter #(.XLEN(XLEN)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start),
    .a       (bus.op_a),
    .b       (bus.op_b),
    .done    (mul_done),
    .product (mul_product)
  );

  // Hold the destination fields of an in-flight multiply.
  always_ff @(posedge clk) begin
    if (rst) begin
      mul_rw <= 1'b0;
      mul_rd <= '0;
    end else if (mul_start) begin
      mul_rw <= bus.regwrite_in;
      mul_rd <= bus.rd_in;
    end
  end
`else
  assign is_mul      = 1'b0;
  assign mul_done    = 1'b0;
  assign mul_product = '0;
  assign mul_rw      = 1'b0;
  assign mul_rd      = '0;
`endif

  // Single-cycle ALU result for the op currently offered by the decoder.
  always_comb begin
    alu_res = '0;
    case (alu_op_e'(bus.alu_control))
      ALU_AND: alu_res = bus.op_a & bus.op_b;
      ALU_OR:  alu_res = bus.op_a | bus.op_b;
      ALU_ADD: alu_res = bus.op_a + bus.op_b;
      ALU_SLL: alu_res = bus.op_a << bus.op_b[4:0];
      ALU_SUB: alu_res = bus.op_a - bus.op_b;
      ALU_SRL: alu_res = bus.op_a >> bus.op_b[4:0];
      ALU_XOR: alu_res = bus.op_a ^ bus.op_b;
      default: alu_res = '0;
    endcase
  end

  // Next state and the contents of the next writeback beat.
  always_comb begin
    state_next = state;
    nx_vld     = 1'b0;
    nx_rw      = 1'b0;
    nx_ill     = 1'b0;
    nx_rd      = '0;
    nx_data    = '0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (is_mul) begin
            state_next = MUL;
          end else begin
            nx_vld = 1'b1;
            nx_rd  = bus.rd_in;
            if (legal) begin
              nx_rw   = bus.regwrite_in;
              nx_data = alu_res;
            end else begin
              nx_ill = 1'b1;
            end
          end
        end else if (bus.halt_req) begin
          state_next = HALTED;
        end
      end
      MUL: begin
        if (mul_done) begin
          nx_vld     = 1'b1;
          nx_rw      = mul_rw;
          nx_rd      = mul_rd;
          nx_data    = mul_product;
          state_next = IDLE;
        end
      end
      HALTED:  state_next = HALTED;
      default: state_next = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Writeback beat register; every field returns to zero between beats.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.wb_valid    <= 1'b0;
      bus.wb_regwrite <= 1'b0;
      bus.wb_rd       <= '0;
      bus.wb_data     <= '0;
      bus.illegal_op  <= 1'b0;
    end else begin
      bus.wb_valid    <= nx_vld;
      bus.wb_regwrite <= nx_rw;
      bus.wb_rd       <= nx_rd;
      bus.wb_data     <= nx_data;
      bus.illegal_op  <= nx_ill;
    end
  end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: vector table, MUL/halt/reset sequences, random stream vs model.
// Latency: n/a.
// Backpressure: n/a.
module tb_exec_stage;

  localparam int XLEN = 32;
`ifdef EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  exec_if #(.XLEN(XLEN)) bus();
  exec_stage #(.XLEN(XLEN)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [3:0]  op;
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp_d;
    logic        exp_rw;
    logic        exp_ill;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic rw,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    bus.in_valid    = v;
    bus.alu_control = op;
    bus.regwrite_in = rw;
    bus.rd_in       = rd;
    bus.op_a        = a;
    bus.op_b        = b;
    #1;
  endtask

  task automatic check_beat(input string name, input logic v, input logic rw,
                            input logic [4:0] rd, input logic [31:0] d, input logic ill);
    chk({name, ".wb_valid"}, bus.wb_valid, v);
    chk({name, ".illegal_op"}, bus.illegal_op, v ? ill : 1'b0);
    if (v) begin
      chk({name, ".wb_regwrite"}, bus.wb_regwrite, rw);
      chk({name, ".wb_rd"}, bus.wb_rd, rd);
      chk({name, ".wb_data"}, bus.wb_data, d);
    end
  endtask

  // Architectural meaning of each code, straight from the op definitions.
  function automatic void ref_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                 input logic rw_in, output logic [31:0] d, output logic rw,
                                 output logic ill);
    logic [63:0] p;
    ill = 1'b0;
    d   = '0;
    case (op)
      4'd0: d = a & b;
      4'd1: d = a | b;
      4'd2: d = a + b;
      4'd3: d = a << b[4:0];
      4'd4: d = a - b;
      4'd5: d = a >> b[4:0];
      4'd6: begin
        if (MUL_EN) begin
          p = {32'd0, a} * {32'd0, b};
          d = p[31:0];
        end else begin
          ill = 1'b1;
        end
      end
      4'd7: d = a ^ b;
      default: ill = 1'b1;
    endcase
    if (ill) begin
      d  = '0;
      rw = 1'b0;
    end else begin
      rw = rw_in;
    end
  endfunction

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 4))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [3:0]  op;
    logic        v, rw, exp_v, exp_rw, exp_ill, st_rw;
    logic [4:0]  rd, exp_rd, st_rd;
    logic [31:0] a, b, exp_d, st_d;
    int          mul_left;

    tbl[0]  = '{4'b0010, 1'b1, 5'd5,  32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000, 1'b1, 1'b0};
    tbl[1]  = '{4'b0100, 1'b1, 5'd6,  32'h0000_0000, 32'h0000_0001, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[2]  = '{4'b0011, 1'b1, 5'd7,  32'h0000_0001, 32'h0000_001F, 32'h8000_0000, 1'b1, 1'b0};
    tbl[3]  = '{4'b0101, 1'b0, 5'd8,  32'h8000_0000, 32'h0000_0004, 32'h0800_0000, 1'b0, 1'b0};
    tbl[4]  = '{4'b0000, 1'b1, 5'd9,  32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b1, 1'b0};
    tbl[5]  = '{4'b0001, 1'b1, 5'd10, 32'h0F0F_0000, 32'h0000_00F0, 32'h0F0F_00F0, 1'b1, 1'b0};
    tbl[6]  = '{4'b0111, 1'b1, 5'd11, 32'hAAAA_5555, 32'hFFFF_0000, 32'h5555_5555, 1'b1, 1'b0};
    tbl[7]  = '{4'b0011, 1'b1, 5'd12, 32'h0000_0001, 32'h0000_0023, 32'h0000_0008, 1'b1, 1'b0};
    tbl[8]  = '{4'b1010, 1'b1, 5'd13, 32'h0000_0001, 32'h0000_0002, 32'h0000_0000, 1'b0, 1'b1};
    tbl[9]  = '{4'b0010, 1'b1, 5'd0,  32'h0000_0002, 32'h0000_0003, 32'h0000_0005, 1'b1, 1'b0};
    tbl[10] = '{4'b0101, 1'b1, 5'd31, 32'hFFFF_FFFF, 32'hFFFF_FFE0, 32'hFFFF_FFFF, 1'b1, 1'b0};
    tbl[11] = '{4'b1111, 1'b1, 5'd1,  32'h1234_5678, 32'h1111_1111, 32'h0000_0000, 1'b0, 1'b1};

    // Reset state
    rst = 1'b1;
    bus.halt_req = 1'b0;
    drive(1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    step();
    step();
    chk("rst.in_ready", bus.in_ready, 1'b0);
    chk("rst.wb_valid", bus.wb_valid, 1'b0);
    chk("rst.wb_regwrite", bus.wb_regwrite, 1'b0);
    chk("rst.wb_rd", bus.wb_rd, 5'd0);
    chk("rst.wb_data", bus.wb_data, 32'd0);
    chk("rst.illegal_op", bus.illegal_op, 1'b0);
    chk("rst.halted", bus.halted, 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst.in_ready", bus.in_ready, 1'b1);

    // Back-to-back single-cycle vectors
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, tbl[i].op, tbl[i].rw, tbl[i].rd, tbl[i].a, tbl[i].b);
      chk($sformatf("tbl%0d.in_ready", i), bus.in_ready, 1'b1);
      step();
      check_beat($sformatf("tbl%0d", i), 1'b1, tbl[i].exp_rw, tbl[i].rd, tbl[i].exp_d, tbl[i].exp_ill);
    end
    drive(1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    step();
    check_beat("tbl.drain", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    // MUL 0xFFFFFFFF * 3, operands disturbed while running
    drive(1'b1, 4'b0110, 1'b1, 5'd3, 32'hFFFF_FFFF, 32'h0000_0003);
    chk("mul.in_ready", bus.in_ready, 1'b1);
    step();
    if (MUL_EN) begin
      for (int j = 1; j <= 31; j++) begin
        chk($sformatf("mul.busy%0d.in_ready", j), bus.in_ready, 1'b0);
        chk($sformatf("mul.busy%0d.wb_valid", j), bus.wb_valid, 1'b0);
        drive(1'b1, 4'b0010, 1'b1, 5'd9, $urandom, $urandom);
        step();
      end
      chk("mul.busy32.in_ready", bus.in_ready, 1'b0);
      drive(1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
      step();
      check_beat("mul.beat", 1'b1, 1'b1, 5'd3, 32'hFFFF_FFFD, 1'b0);
      chk("mul.ready_back", bus.in_ready, 1'b1);
    end else begin
      check_beat("mul_off.beat", 1'b1, 1'b0, 5'd3, 32'd0, 1'b1);
      drive(1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    end
    step();
    check_beat("mul.after", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);

    // Random stream against the model
    mul_left = 0;
    st_d = '0; st_rd = '0; st_rw = 1'b0;
    for (int c = 0; c < 800; c++) begin
      v  = ($urandom_range(0, 4) != 0);
      op = 4'($urandom_range(0, 15));
      if (op == 4'd6 && $urandom_range(0, 3) != 0) op = 4'd2;
      rw = 1'($urandom);
      rd = 5'($urandom);
      a  = rnd_word();
      b  = rnd_word();
      drive(v, op, rw, rd, a, b);
      chk("rnd.in_ready", bus.in_ready, mul_left == 0);
      exp_v = 1'b0; exp_rw = 1'b0; exp_rd = '0; exp_d = '0; exp_ill = 1'b0;
      if (v && mul_left == 0) begin
        ref_op(op, a, b, rw, exp_d, exp_rw, exp_ill);
        if (MUL_EN && op == 4'd6) begin
          mul_left = XLEN;
          st_d = exp_d; st_rd = rd; st_rw = exp_rw;
        end else begin
          exp_v  = 1'b1;
          exp_rd = rd;
        end
      end else if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) begin
          exp_v = 1'b1; exp_d = st_d; exp_rd = st_rd; exp_rw = st_rw; exp_ill = 1'b0;
        end
      end
      step();
      check_beat("rnd", exp_v, exp_rw, exp_rd, exp_d, exp_ill);
    end
    // let any multiply still running finish before the directed sequences
    drive(1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int j = 0; j < 40; j++) step();

    // rst at iteration 15 of a MUL aborts it
    drive(1'b1, 4'b0110, 1'b1, 5'd17, 32'h1234_5678, 32'h0000_0009);
    step();
    drive(1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    for (int j = 1; j <= 15; j++) step();
    rst = 1'b1;
    step();
    chk("abort.in_ready", bus.in_ready, 1'b0);
    check_beat("abort.rst", 1'b0, 1'b0, 5'd0, 32'd0, 1'b0);
    chk("abort.wb_data", bus.wb_data, 32'd0);
    chk("abort.wb_rd", bus.wb_rd, 5'd0);
    chk("abort.wb_regwrite", bus.wb_regwrite, 1'b0);
    rst = 1'b0;
    #1;
    chk("abort.ready_after", bus.in_ready, 1'b1);
    for (int j = 0; j < 40; j++) begin
      step();
      chk($sformatf("abort.no_beat%0d", j), bus.wb_valid, 1'b0);
    end

    // halt_req raised during work: work finishes, then the stage parks
    if (MUL_EN) begin
      drive(1'b1, 4'b0110, 1'b1, 5'd4, 32'd5, 32'd7);
      step();
      for (int j = 1; j <= 10; j++) step();
      bus.halt_req = 1'b1;
      for (int j = 11; j <= 31; j++) begin
        step();
        chk($sformatf("halt.busy%0d.in_ready", j), bus.in_ready, 1'b0);
      end
      step();
      check_beat("halt.mul_beat", 1'b1, 1'b1, 5'd4, 32'd35, 1'b0);
      chk("halt.not_yet", bus.halted, 1'b0);
    end else begin
      drive(1'b1, 4'b0010, 1'b1, 5'd4, 32'd5, 32'd7);
      step();
      check_beat("halt.add_beat", 1'b1, 1'b1, 5'd4, 32'd12, 1'b0);
      chk("halt.not_yet", bus.halted, 1'b0);
      bus.halt_req = 1'b1;
      #1;
    end
    chk("halt.req_ready", bus.in_ready, 1'b0);
    step();
    chk("halt.halted", bus.halted, 1'b1);
    for (int j = 0; j < 5; j++) begin
      chk($sformatf("halt.park%0d.in_ready", j), bus.in_ready, 1'b0);
      chk($sformatf("halt.park%0d.wb_valid", j), bus.wb_valid, 1'b0);
      step();
    end
    bus.halt_req = 1'b0;
    #1;
    chk("halt.sticky_ready", bus.in_ready, 1'b0);
    step();
    chk("halt.sticky", bus.halted, 1'b1);
    chk("halt.sticky_valid", bus.wb_valid, 1'b0);

    // rst releases the halt
    rst = 1'b1;
    drive(1'b0, 4'd0, 1'b0, 5'd0, 32'd0, 32'd0);
    step();
    rst = 1'b0;
    #1;
    chk("unhalt.halted", bus.halted, 1'b0);
    chk("unhalt.in_ready", bus.in_ready, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
